// File: rtl/smartcar_pkg.sv
// smartcar_pkg
// Types and default constants shared by the SmartCar panel button scanner.
//   arb_state_t     : arbiter FSM states (IDLE, OFFER)
//   TICK_DIV_DEF    : default clocks per debounce sample tick
//   STABLE_CNT_DEF  : default number of equal samples needed to accept a level
//   N_BTN_DEF       : default number of panel buttons
package smartcar_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_t;

  localparam int TICK_DIV_DEF   = 25;
  localparam int STABLE_CNT_DEF = 3;
  localparam int N_BTN_DEF      = 4;

endpackage

// File: rtl/button_scan_arbiter_if.sv
// button_scan_arbiter_if
// Valid/ready event channel from the button arbiter to the command decoder.
//   cmd_valid : event offered (driven by master)
//   cmd_ready : decoder can accept (driven by slave)
//   cmd_id    : index of the offered button (driven by master)
interface button_scan_arbiter_if #(
  parameter int ID_W = 2
);

  logic            cmd_valid;
  logic            cmd_ready;
  logic [ID_W-1:0] cmd_id;

  modport master (output cmd_valid, output cmd_id, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_id, output cmd_ready);

endinterface

// File: rtl/button_scan_arbiter_debounce.sv
// btn_debounce
// Synchronizes and debounces one active-low button, emitting a one-clk
// press pulse when the debounced level falls (release produces nothing).
//   clk   : system clock
//   CR    : asynchronous clear, active-high
//   tick  : shared sample strobe from the prescaler
//   raw   : raw button pin, 0 = pressed
//   press : one-clk pulse on an accepted 1->0 transition
module btn_debounce
  import smartcar_pkg::*;
#(
  parameter int STABLE_CNT = STABLE_CNT_DEF
) (
  input  logic clk,
  input  logic CR,
  input  logic tick,
  input  logic raw,
  output logic press
);

  localparam int CW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;

  logic [1:0]    sync_q;
  logic          sync;
  logic          stable_q;
  logic [CW-1:0] cnt_q;

  assign sync = sync_q[1];

  always_ff @(posedge clk or posedge CR) begin
    if (CR) begin
      sync_q   <= 2'b11;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press    <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      press  <= 1'b0;
      if (tick) begin
        if (sync == stable_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CW'(STABLE_CNT - 1)) begin
          // Accept the new level; only a fall to 0 counts as a press.
          stable_q <= sync;
          cnt_q    <= '0;
          press    <= ~sync;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/button_scan_arbiter.sv
// button_scan_arbiter
// Debounces a bank of active-low panel buttons, latches each press as a
// pending event and hands events one at a time to the command decoder with
// round-robin priority over a valid/ready channel.
//   clk     : system clock
//   CR      : asynchronous clear, active-high
//   button  : raw button pins, 0 = pressed
//   cmd     : event channel (master side: cmd_valid, cmd_id out; cmd_ready in)
//   pending : per-button event-waiting flags
//
// state | meaning
// IDLE  | no event offered; picks the next pending button if any
// OFFER | cmd_valid high with a frozen cmd_id until cmd_ready
module button_scan_arbiter
  import smartcar_pkg::*;
#(
  parameter int N_BTN      = N_BTN_DEF,
  parameter int TICK_DIV   = TICK_DIV_DEF,
  parameter int STABLE_CNT = STABLE_CNT_DEF
) (
  input  logic                         clk,
  input  logic                         CR,
  input  logic [N_BTN-1:0]             button,
  button_scan_arbiter_if.master        cmd,
  output logic [N_BTN-1:0]             pending
);

  localparam int ID_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;
  localparam int DW   = $clog2(TICK_DIV);

  logic [DW-1:0]    div_q;
  logic             tick;
  logic [N_BTN-1:0] press_vec;
  logic [N_BTN-1:0] clr_mask;

  arb_state_t       state_q, state_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [ID_W-1:0]  last_q, last_d;
  logic [ID_W-1:0]  pick;
  logic             found;

  assign tick = (div_q == DW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge CR) begin
    if (CR) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_debounce #(
      .STABLE_CNT(STABLE_CNT)
    ) u_deb (
      .clk  (clk),
      .CR   (CR),
      .tick (tick),
      .raw  (button[g]),
      .press(press_vec[g])
    );
  end

  // Round-robin search: first pending bit starting just after last grant.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= N_BTN; k++) begin
      if (!found && pending[(int'(last_q) + k) % N_BTN]) begin
        found = 1'b1;
        pick  = ID_W'((int'(last_q) + k) % N_BTN);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    last_d   = last_q;
    clr_mask = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          id_d    = pick;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (cmd.cmd_ready) begin
          clr_mask = N_BTN'(1) << id_q;
          last_d   = id_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge CR) begin
    if (CR) begin
      state_q <= IDLE;
      id_q    <= '0;
      last_q  <= ID_W'(N_BTN - 1);
      pending <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      last_q  <= last_d;
      // A press landing on the clearing handshake keeps its bit set.
      pending <= (pending & ~clr_mask) | press_vec;
    end
  end

  assign cmd.cmd_valid = (state_q == OFFER);
  assign cmd.cmd_id    = id_q;

endmodule

// File: tb/tb_button_scan_arbiter.sv
module tb_button_scan_arbiter;

  localparam int N  = 4;
  localparam int TD = 4;
  localparam int SC = 3;

  logic       clk = 1'b0;
  logic       CR  = 1'b1;
  logic [3:0] button = 4'hF;
  logic [3:0] pending;
  logic [3:0] b;

  button_scan_arbiter_if #(.ID_W(2)) bus();

  button_scan_arbiter #(
    .N_BTN(N), .TICK_DIV(TD), .STABLE_CNT(SC)
  ) dut (
    .clk    (clk),
    .CR     (CR),
    .button (button),
    .cmd    (bus),
    .pending(pending)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  int got_q[$];
  int exp_q[$];
  int rd = 0;
  int valid_cycles = 0;
  int last_grant;

  // Handshake monitor: a grant is recorded when valid & ready before the edge.
  always @(negedge clk) begin
    if (!CR && bus.cmd_valid) begin
      valid_cycles++;
      if (bus.cmd_ready) got_q.push_back(int'(bus.cmd_id));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(string tag, int obs, int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference arbiter: grants the pressed set in circular order after the last grant.
  function automatic void model_grants(int mask);
    int base = last_grant;
    for (int k = 1; k <= N; k++) begin
      int idx = (base + k) % N;
      if (((mask >> idx) & 1) == 1) begin
        exp_q.push_back(idx);
        last_grant = idx;
      end
    end
  endfunction

  task automatic wait_grants(string tag, bit rnd);
    int n = exp_q.size();
    int budget = 0;
    while (got_q.size() < rd + n && budget < 300) begin
      bus.cmd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      step(1);
      budget++;
    end
    bus.cmd_ready = 1'b0;
    check({tag, "_count"}, got_q.size() - rd, n);
    for (int i = 0; i < n; i++) begin
      if (rd + i < got_q.size()) check({tag, "_id"}, got_q[rd + i], exp_q[i]);
    end
    rd = got_q.size();
    exp_q.delete();
  endtask

  task automatic wait_valid(string tag);
    int n = 0;
    while (!bus.cmd_valid && n < 60) begin
      step(1);
      n++;
    end
    check({tag, "_valid_seen"}, int'(bus.cmd_valid), 1);
  endtask

  initial begin
    int n, v0, bad, mask, gb, gs, glen, dbl;
    bus.cmd_ready = 1'b0;
    last_grant = N - 1;

    // Reset
    step(3);
    check("rst_valid", int'(bus.cmd_valid), 0);
    check("rst_pending", int'(pending), 0);
    check("rst_id", int'(bus.cmd_id), 0);
    CR = 1'b0;
    step(100);
    check("idle_events", got_q.size(), 0);
    check("idle_valid_cycles", valid_cycles, 0);
    check("idle_pending", int'(pending), 0);

    // Single press of button 2 with latency bounds
    button = 4'b1011;
    n = 0;
    while (pending == 4'b0000 && n < 40) begin
      step(1);
      n++;
    end
    check("press_latency_in_range", int'(n >= 12 && n <= 15), 1);
    check("press_pending", int'(pending), 4'b0100);
    check("press_valid_not_yet", int'(bus.cmd_valid), 0);
    step(1);
    check("press_valid", int'(bus.cmd_valid), 1);
    check("press_id", int'(bus.cmd_id), 2);
    model_grants(4'b0100);
    wait_grants("single", 1'b0);
    check("single_pending_cleared", int'(pending), 0);
    button = 4'hF;
    step(40);

    // Glitch of exactly 2 ticks on button 1
    v0 = valid_cycles;
    button = 4'b1101;
    step(8);
    button = 4'hF;
    step(40);
    check("glitch_pending", int'(pending), 0);
    check("glitch_valid_cycles", valid_cycles - v0, 0);

    // Round-robin from a fresh reset: buttons 0,1,3 together, twice
    CR = 1'b1;
    step(2);
    CR = 1'b0;
    last_grant = N - 1;
    step(5);
    bus.cmd_ready = 1'b1;
    button = 4'b0100;
    step(24);
    button = 4'hF;
    model_grants(4'b1011);
    wait_grants("rr_first", 1'b0);
    step(24);
    bus.cmd_ready = 1'b1;
    button = 4'b0100;
    step(24);
    button = 4'hF;
    model_grants(4'b1011);
    wait_grants("rr_second", 1'b0);
    step(24);

    // Backpressure on button 2 while button 0 is pressed
    bus.cmd_ready = 1'b0;
    button = 4'b1011;
    wait_valid("bp");
    check("bp_id", int'(bus.cmd_id), 2);
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      if (c == 5) button = 4'b1010;
      if (!bus.cmd_valid || bus.cmd_id != 2'd2) bad++;
      step(1);
    end
    check("bp_stable_violations", bad, 0);
    check("bp_pending", int'(pending), 4'b0101);
    button = 4'hF;
    model_grants(4'b0100);
    model_grants(4'b0001);
    wait_grants("bp_order", 1'b0);
    step(24);

    // Reset while offering
    button = 4'b1101;
    wait_valid("rst_offer");
    button = 4'hF;
    #2;
    CR = 1'b1;
    #1;
    check("rst_offer_valid", int'(bus.cmd_valid), 0);
    check("rst_offer_pending", int'(pending), 0);
    check("rst_offer_id", int'(bus.cmd_id), 0);
    step(2);
    CR = 1'b0;
    last_grant = N - 1;
    v0 = valid_cycles;
    step(40);
    check("post_rst_valid_cycles", valid_cycles - v0, 0);
    check("post_rst_events", got_q.size() - rd, 0);

    // Randomized rounds: pressed set with optional glitch and double press
    for (int r = 0; r < 20; r++) begin
      mask = $urandom_range(1, 15);
      dbl  = $urandom_range(0, 1);
      glen = $urandom_range(1, 8);
      gs   = $urandom_range(0, 12);
      gb   = 0;
      if (mask != 15) begin
        gb = $urandom_range(0, 3);
        while (((mask >> gb) & 1) == 1) gb = $urandom_range(0, 3);
      end
      for (int p = 0; p <= dbl; p++) begin
        for (int c = 0; c < 24; c++) begin
          b = ~mask[3:0];
          if (mask != 15 && c >= gs && c < gs + glen) b[gb] = 1'b0;
          button = b;
          step(1);
        end
        button = 4'hF;
        step(24);
      end
      model_grants(mask);
      wait_grants("rand", 1'b1);
      check("rand_pending_cleared", int'(pending), 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
